i2s_tx_framer: RTL and testbench
================================

Name: i2s_tx_framer

Overview:
- Parametrised master-mode I2S / left-justified serial audio transmitter for the zxaudio path.
- Generates bclk and lrclk from mclk and serialises stereo samples onto sdata.
- Accepts samples through a valid/ready handshake with a one-entry holding buffer.
- Handles underrun by transmitting zeros or repeating the last sample, and flags each underrun.

Parameters:
- DATA_WIDTH, 16: sample bits per channel, 1..SLOT_WIDTH.
- SLOT_WIDTH, 32: bclk periods per channel slot; frame = 2*SLOT_WIDTH bclk periods.
- BCLK_DIV, 4: mclk cycles per bclk period; even, >=2.
- FORMAT, 0: 0 = I2S (data delayed one bclk after lrclk edge); 1 = left-justified (no delay).
- UNDERRUN_ZERO, 1: 1 = send zero frame on underrun; 0 = repeat previous frame.

Ports:
- mclk, in, 1: sole clock; all logic on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: 1 = generate clocks and transmit; 0 = idle.
- s_valid, in, 1: sample pair offered.
- s_ready, out, 1: holding buffer empty.
- left_chan, in, DATA_WIDTH: signed left sample.
- right_chan, in, DATA_WIDTH: signed right sample.
- bclk, out, 1: bit clock.
- lrclk, out, 1: 0 = left slot, 1 = right slot.
- sdata, out, 1: serial data, MSB first.
- frame_start, out, 1: one-mclk pulse when a new frame is loaded.
- underrun, out, 1: one-mclk pulse when a load found no sample.

Behaviour:
- Reset values:
  - Outputs: bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, s_ready=1.
  - Internal state: buffer empty, frame register 0, div_cnt=BCLK_DIV-1, p=2*SLOT_WIDTH-1.
- Idle (enable=0):
  - div_cnt, p, frame register and outputs forced to their reset values on the next edge.
  - Holding buffer and handshake keep operating.
- Tick:
  - A tick is any enabled cycle with div_cnt==BCLK_DIV-1.
  - The first enabled cycle after idle is therefore a tick.
  - On a tick: div_cnt->0 and p->(p+1) mod 2S, where S=SLOT_WIDTH. Otherwise div_cnt increments.
- Registered outputs, all updated on the same mclk edge:
  - bclk = (div_cnt >= BCLK_DIV/2), i.e. low for the first half of the period.
  - Data changes on the bclk falling edge; the receiver samples on the rising edge.
  - lrclk = (p >= S).
  - d = 1 if FORMAT==0, else 0; q = (p - d) mod 2S.
  - Channel = right if q >= S, else left; k = q mod S.
  - sdata = chan[DATA_WIDTH-1-k] when k < DATA_WIDTH, else 0 (slot padding).
- Load event:
  - Occurs on the tick that moves p to d, i.e. q becomes 0.
  - The frame register is latched there, so the last bit of the prior frame (I2S, p=0) still comes from the old frame.
- Handshake:
  - s_ready = !buf_full; an accept is s_valid && s_ready.
  - Inputs are captured in the accept cycle.
  - s_ready is low from the cycle after an accept until the cycle after the load that drains the buffer.
- At the load event:
  - Buffer full: frame <- buffer; buffer empties; frame_start pulses.
  - Buffer empty with a same-cycle accept: bypass. Frame <- inputs, buffer stays empty, no underrun, frame_start pulses.
  - Buffer empty and no accept: frame <- 0 (UNDERRUN_ZERO=1) or unchanged (0); underrun and frame_start both pulse.
- Arithmetic: samples are passed bit-exact, with no sign extension into padding. Padding bits are always 0.
- Reset mid-frame: immediate return to reset state; any buffered sample is discarded.
- enable dropped mid-frame: the frame is abandoned and restarts from p=0 on re-enable.

Test Plan:
1. Left-justified basic (FORMAT=1, DATA=16, SLOT=16, DIV=4), left=16'hA5C3, right=16'h0F0F before enable, then enable.
   - bclk period 4 mclk.
   - sdata during lrclk=0 is 1010010111000011; during lrclk=1 is 0000111100001111.
   - frame_start pulses at the first tick; no underrun.
2. I2S delay (FORMAT=0, same samples).
   - Left MSB appears one bclk after lrclk falls; right LSB '1' appears in bit 0 of the next frame.
   - sdata is 0 at p=0 of the first frame.
3. Padding (DATA=24, SLOT=32, FORMAT=0), left=24'h800001.
   - Slot bits are 1, then 22 zeros, then 1, then 8 zeros.
   - lrclk is high for exactly 32 bclk periods.
4. Backpressure: offer three pairs back-to-back with s_valid held high.
   - First accepted immediately; second accepted while s_ready=1 and held.
   - Third waits with s_ready=0 until the cycle after the next load.
   - Frames appear in order and none are lost.
5. Underrun: supply one pair, then none.
   - UNDERRUN_ZERO=1: next frame is all-zero sdata, with underrun pulsed once per frame.
   - UNDERRUN_ZERO=0: the previous frame bits repeat.
6. Async reset asserted mid-slot (p=7, div_cnt=2).
   - All outputs 0 and s_ready=1 with no mclk edge.
   - After release and enable, transmission restarts at p=0, with the buffer empty so underrun fires.

Source files
------------

// File: rtl/i2s_tx_framer.sv
// Master-mode I2S / left-justified stereo transmitter: divides mclk into bclk/lrclk
// and shifts out one sample pair per frame from a one-entry holding buffer.
module i2s_tx_framer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SLOT_WIDTH    = 32,
    parameter int unsigned BCLK_DIV      = 4,
    parameter int unsigned FORMAT        = 0,
    parameter int unsigned UNDERRUN_ZERO = 1
) (
    input  logic                  mclk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] left_chan,
    input  logic [DATA_WIDTH-1:0] right_chan,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int unsigned FRAME_LEN = 2 * SLOT_WIDTH;
    localparam int unsigned PW        = $clog2(FRAME_LEN);
    localparam int unsigned CW        = $clog2(BCLK_DIV);
    localparam int unsigned DLY       = (FORMAT == 0) ? 1 : 0;

    localparam logic [CW-1:0] DIV_MAX  = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF = CW'(BCLK_DIV / 2);
    localparam logic [PW-1:0] P_MAX    = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] P_LOAD   = PW'(DLY);
    localparam logic [PW-1:0] SLOT     = PW'(SLOT_WIDTH);

    logic [CW-1:0]         div_q, div_d;
    logic [PW-1:0]         p_q, p_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic                  bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                  frame_start_q, frame_start_d, underrun_q, underrun_d;

    logic                  accept, tick, load;
    logic [PW-1:0]         q, k;
    logic [DATA_WIDTH-1:0] chan;
    logic [SLOT_WIDTH-1:0] slot;

    assign accept = s_valid && !buf_full_q;

    // Next-state: bit-clock divider, frame position, buffer/frame loading, output bits
    always_comb begin
        div_d         = div_q;
        p_d           = p_q;
        buf_full_d    = buf_full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        frame_l_d     = frame_l_q;
        frame_r_d     = frame_r_q;
        bclk_d        = 1'b0;
        lrclk_d       = 1'b0;
        sdata_d       = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        tick          = 1'b0;
        load          = 1'b0;
        q             = '0;
        k             = '0;
        chan          = '0;
        slot          = '0;

        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = left_chan;
            buf_r_d    = right_chan;
        end

        if (!enable) begin
            div_d     = DIV_MAX;
            p_d       = P_MAX;
            frame_l_d = '0;
            frame_r_d = '0;
        end else begin
            tick = (div_q == DIV_MAX);
            if (tick) begin
                div_d = '0;
                p_d   = (p_q == P_MAX) ? '0 : p_q + PW'(1);
            end else begin
                div_d = div_q + CW'(1);
            end

            // Frame latches when the bit about to go out is the left MSB
            load = tick && (p_d == P_LOAD);
            if (load) begin
                frame_start_d = 1'b1;
                if (buf_full_q) begin
                    frame_l_d  = buf_l_q;
                    frame_r_d  = buf_r_q;
                    buf_full_d = 1'b0;
                end else if (accept) begin
                    frame_l_d  = left_chan;
                    frame_r_d  = right_chan;
                    buf_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                    if (UNDERRUN_ZERO != 0) begin
                        frame_l_d = '0;
                        frame_r_d = '0;
                    end
                end
            end

            bclk_d  = (div_d >= DIV_HALF);
            lrclk_d = (p_d >= SLOT);

            if ((DLY != 0) && (p_d == '0)) begin
                q = P_MAX;
            end else begin
                q = p_d - P_LOAD;
            end
            if (q >= SLOT) begin
                k    = q - SLOT;
                chan = frame_r_d;
            end else begin
                k    = q;
                chan = frame_l_d;
            end

            // MSB-align the sample in the slot; shifting past it yields zero padding
            slot    = SLOT_WIDTH'(chan) << (SLOT_WIDTH - DATA_WIDTH);
            slot    = slot << k;
            sdata_d = slot[SLOT_WIDTH-1];
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= DIV_MAX;
            p_q           <= P_MAX;
            buf_full_q    <= 1'b0;
            buf_l_q       <= '0;
            buf_r_q       <= '0;
            frame_l_q     <= '0;
            frame_r_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            p_q           <= p_d;
            buf_full_q    <= buf_full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_ready     = !buf_full_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Directed bench for i2s_tx_framer: three configurations share stimulus,
// one selected at a time; bits are captured on each bclk rising edge.
module tb_i2s_tx_framer;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        valid;
    logic [23:0] l_in;
    logic [23:0] r_in;
    int          sel;
    int          checks = 0;
    int          errors = 0;

    logic lj_ready, lj_bclk, lj_lrclk, lj_sdata, lj_fs, lj_ur;
    logic i2_ready, i2_bclk, i2_lrclk, i2_sdata, i2_fs, i2_ur;
    logic pd_ready, pd_bclk, pd_lrclk, pd_sdata, pd_fs, pd_ur;
    logic o_ready, o_bclk, o_lrclk, o_sdata, o_fs, o_ur;

    always #5 mclk = ~mclk;

    i2s_tx_framer #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .BCLK_DIV(4), .FORMAT(1), .UNDERRUN_ZERO(0)) u_lj (
        .mclk(mclk), .reset_n(reset_n), .enable(en && sel == 0), .s_valid(valid && sel == 0),
        .s_ready(lj_ready), .left_chan(l_in[15:0]), .right_chan(r_in[15:0]), .bclk(lj_bclk),
        .lrclk(lj_lrclk), .sdata(lj_sdata), .frame_start(lj_fs), .underrun(lj_ur));

    i2s_tx_framer #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .BCLK_DIV(4), .FORMAT(0), .UNDERRUN_ZERO(1)) u_i2 (
        .mclk(mclk), .reset_n(reset_n), .enable(en && sel == 1), .s_valid(valid && sel == 1),
        .s_ready(i2_ready), .left_chan(l_in[15:0]), .right_chan(r_in[15:0]), .bclk(i2_bclk),
        .lrclk(i2_lrclk), .sdata(i2_sdata), .frame_start(i2_fs), .underrun(i2_ur));

    i2s_tx_framer #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(4), .FORMAT(0), .UNDERRUN_ZERO(1)) u_pd (
        .mclk(mclk), .reset_n(reset_n), .enable(en && sel == 2), .s_valid(valid && sel == 2),
        .s_ready(pd_ready), .left_chan(l_in), .right_chan(r_in), .bclk(pd_bclk),
        .lrclk(pd_lrclk), .sdata(pd_sdata), .frame_start(pd_fs), .underrun(pd_ur));

    always_comb begin
        case (sel)
            0:       {o_ready, o_bclk, o_lrclk, o_sdata, o_fs, o_ur} = {lj_ready, lj_bclk, lj_lrclk, lj_sdata, lj_fs, lj_ur};
            1:       {o_ready, o_bclk, o_lrclk, o_sdata, o_fs, o_ur} = {i2_ready, i2_bclk, i2_lrclk, i2_sdata, i2_fs, i2_ur};
            default: {o_ready, o_bclk, o_lrclk, o_sdata, o_fs, o_ur} = {pd_ready, pd_bclk, pd_lrclk, pd_sdata, pd_fs, pd_ur};
        endcase
    end

    task automatic do_reset();
        en = 1'b0; valid = 1'b0; reset_n = 1'b0;
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
    endtask

    // Records sdata/lrclk at each bclk rise plus pulse counts over the window
    task automatic capture(input int nbits, output logic [79:0] bits, output logic [79:0] lr,
                           output logic [23:0] pulses, output int nhi, output int got);
        logic prev;
        int   gap, nfs, nur, nbad;
        bits = '0; lr = '0; nhi = 0; got = 0; gap = 0; nfs = 0; nur = 0; nbad = 0;
        prev = o_bclk;
        for (int c = 0; c < nbits * 4 + 16 && got < nbits; c++) begin
            @(negedge mclk);
            gap++;
            if (o_fs) nfs++;
            if (o_ur) nur++;
            if (o_bclk && !prev) begin
                bits = {bits[78:0], o_sdata};
                lr   = {lr[78:0], o_lrclk};
                if (o_lrclk) nhi++;
                if (got > 0 && gap != 4) nbad++;
                got++;
                gap = 0;
            end
            prev = o_bclk;
        end
        pulses = {8'(nfs), 8'(nur), 8'(nbad)};
        if (got != nbits) $display("FAIL capture_timeout got %0d bits, required %0d", got, nbits);
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_ready} !== 6'b000001) begin
                errors++;
                $display("FAIL reset_state sel=%0d got %b required 000001", s, {o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_ready});
            end
        end
    endtask

    task automatic test_lj_basic();
        logic [79:0] bits, lr; logic [23:0] pl; int nhi, got;
        do_reset(); sel = 0;
        l_in = 24'h00A5C3; r_in = 24'h000F0F; valid = 1'b1;
        @(negedge mclk); valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL lj_ready_after_accept got %b required 0", o_ready); end
        en = 1'b1;
        capture(32, bits, lr, pl, nhi, got);
        checks++;
        if (bits !== 80'h0000_0000_0000_A5C3_0F0F) begin errors++; $display("FAIL lj_bits got %h required a5c30f0f", bits); end
        checks++;
        if (lr !== 80'h0000_0000_0000_0000_FFFF) begin errors++; $display("FAIL lj_lrclk got %h required 0000ffff", lr); end
        checks++;
        if (pl !== 24'h010000) begin errors++; $display("FAIL lj_pulses fs/ur/badperiod got %h required 010000", pl); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL lj_ready_after_load got %b required 1", o_ready); end
    endtask

    task automatic test_underrun_repeat();
        logic [79:0] bits, lr; logic [23:0] pl; int nhi, got;
        for (int f = 0; f < 2; f++) begin
            capture(32, bits, lr, pl, nhi, got);
            checks++;
            if (bits !== 80'h0000_0000_0000_A5C3_0F0F) begin errors++; $display("FAIL repeat_bits frame %0d got %h required a5c30f0f", f, bits); end
            checks++;
            if (pl !== 24'h010100) begin errors++; $display("FAIL repeat_pulses frame %0d got %h required 010100", f, pl); end
        end
    endtask

    task automatic test_i2s_delay();
        logic [79:0] bits, lr, exp_b, exp_l; logic [23:0] pl; int nhi, got;
        do_reset(); sel = 1;
        l_in = 24'h00A5C3; r_in = 24'h000F0F; valid = 1'b1;
        @(negedge mclk); valid = 1'b0;
        en = 1'b1;
        capture(33, bits, lr, pl, nhi, got);
        exp_b = 80'({1'b0, 16'hA5C3, 16'h0F0F});
        exp_l = 80'({16'h0000, 16'hFFFF, 1'b0});
        checks++;
        if (bits !== exp_b) begin errors++; $display("FAIL i2s_bits got %h required %h", bits, exp_b); end
        checks++;
        if (lr !== exp_l) begin errors++; $display("FAIL i2s_lrclk got %h required %h", lr, exp_l); end
        checks++;
        if (pl !== 24'h010000) begin errors++; $display("FAIL i2s_pulses got %h required 010000", pl); end
    endtask

    task automatic test_underrun_zero();
        logic [79:0] bits, lr, exp_l; logic [23:0] pl; int nhi, got;
        exp_l = 80'({15'h0000, 16'hFFFF, 1'b0});
        for (int f = 0; f < 2; f++) begin
            capture(32, bits, lr, pl, nhi, got);
            checks++;
            if (bits !== 80'h0) begin errors++; $display("FAIL zero_bits frame %0d got %h required 0", f, bits); end
            checks++;
            if (lr !== exp_l) begin errors++; $display("FAIL zero_lrclk frame %0d got %h required %h", f, lr, exp_l); end
            checks++;
            if (pl !== 24'h010100) begin errors++; $display("FAIL zero_pulses frame %0d got %h required 010100", f, pl); end
        end
    endtask

    task automatic test_idle();
        logic [79:0] bits, lr, exp_l; logic [23:0] pl; int nhi, got;
        en = 1'b0;
        @(negedge mclk);
        checks++;
        if ({o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL idle_state got %b required 000001", {o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_ready});
        end
        repeat (3) @(negedge mclk);
        en = 1'b1;
        capture(33, bits, lr, pl, nhi, got);
        exp_l = 80'({16'h0000, 16'hFFFF, 1'b0});
        checks++;
        if (lr !== exp_l) begin errors++; $display("FAIL idle_restart_lrclk got %h required %h", lr, exp_l); end
        checks++;
        if (pl !== 24'h010100) begin errors++; $display("FAIL idle_restart_pulses got %h required 010100", pl); end
    endtask

    task automatic test_padding();
        logic [79:0] bits, lr, exp_b, exp_l; logic [23:0] pl; int nhi, got;
        do_reset(); sel = 2;
        l_in = 24'h800001; r_in = 24'hC00003; valid = 1'b1;
        @(negedge mclk); valid = 1'b0;
        en = 1'b1;
        capture(65, bits, lr, pl, nhi, got);
        exp_b = 80'({1'b0, 24'h800001, 8'h00, 24'hC00003, 8'h00});
        exp_l = 80'({32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        checks++;
        if (bits !== exp_b) begin errors++; $display("FAIL pad_bits got %h required %h", bits, exp_b); end
        checks++;
        if (lr !== exp_l) begin errors++; $display("FAIL pad_lrclk got %h required %h", lr, exp_l); end
        checks++;
        if (nhi != 32) begin errors++; $display("FAIL pad_lrclk_high got %0d required 32", nhi); end
        checks++;
        if (pl !== 24'h010000) begin errors++; $display("FAIL pad_pulses got %h required 010000", pl); end
    endtask

    task automatic test_back_to_back();
        logic [79:0] bits, lr, exp_b; logic [23:0] pl; int nhi, got;
        logic [15:0] pl_l [3];
        logic [15:0] pl_r [3];
        int acc [3];
        pl_l[0] = 16'h1234; pl_r[0] = 16'h8001;
        pl_l[1] = 16'hFEDC; pl_r[1] = 16'h0001;
        pl_l[2] = 16'h5A5A; pl_r[2] = 16'hC3C3;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        do_reset(); sel = 1;
        en = 1'b1;
        fork
            begin
                int  idx;
                logic pend;
                idx = 0; pend = 1'b0;
                for (int c = 1; c <= 200 && idx < 3; c++) begin
                    @(negedge mclk);
                    if (pend) begin acc[idx] = c; idx++; pend = 1'b0; end
                    if (c >= 4 && idx < 3) begin
                        valid = 1'b1; l_in = 24'(pl_l[idx]); r_in = 24'(pl_r[idx]);
                        if (o_ready) pend = 1'b1;
                    end else begin
                        valid = 1'b0;
                    end
                end
                valid = 1'b0;
            end
            capture(33, bits, lr, pl, nhi, got);
        join
        exp_b = 80'({1'b0, 16'h1234, 16'h8001});
        checks++;
        if (bits !== exp_b) begin errors++; $display("FAIL b2b_frame1 got %h required %h", bits, exp_b); end
        checks++;
        if (pl !== 24'h010000) begin errors++; $display("FAIL b2b_frame1_pulses got %h required 010000", pl); end
        checks++;
        if ({acc[0], acc[1], acc[2]} !== {32'd5, 32'd6, 32'd134}) begin
            errors++;
            $display("FAIL b2b_accept_cycles got %0d %0d %0d required 5 6 134", acc[0], acc[1], acc[2]);
        end
        capture(32, bits, lr, pl, nhi, got);
        checks++;
        if (bits !== 80'h0000_0000_0000_FEDC_0001) begin errors++; $display("FAIL b2b_frame2 got %h required fedc0001", bits); end
        capture(32, bits, lr, pl, nhi, got);
        checks++;
        if (bits !== 80'h0000_0000_0000_5A5A_C3C3) begin errors++; $display("FAIL b2b_frame3 got %h required 5a5ac3c3", bits); end
        checks++;
        if (pl !== 24'h010000) begin errors++; $display("FAIL b2b_frame3_pulses got %h required 010000", pl); end
    endtask

    task automatic test_async_reset();
        logic [79:0] bits, lr, exp_l; logic [23:0] pl; int nhi, got;
        do_reset(); sel = 1;
        l_in = 24'h00F00F; r_in = 24'h00AAAA; valid = 1'b1;
        @(negedge mclk);
        en = 1'b1; l_in = 24'h007FFF; r_in = 24'h00FFFF;
        for (int c = 1; c <= 31; c++) begin
            @(negedge mclk);
            if (c == 8) valid = 1'b0;
        end
        checks++;
        if ({o_bclk, o_ready} !== 2'b10) begin errors++; $display("FAIL rst_pre_state bclk/ready got %b required 10", {o_bclk, o_ready}); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL rst_async_state got %b required 000001", {o_bclk, o_lrclk, o_sdata, o_fs, o_ur, o_ready});
        end
        @(negedge mclk);
        reset_n = 1'b1;
        capture(33, bits, lr, pl, nhi, got);
        exp_l = 80'({16'h0000, 16'hFFFF, 1'b0});
        checks++;
        if (bits !== 80'h0) begin errors++; $display("FAIL rst_restart_bits got %h required 0", bits); end
        checks++;
        if (lr !== exp_l) begin errors++; $display("FAIL rst_restart_lrclk got %h required %h", lr, exp_l); end
        checks++;
        if (pl !== 24'h010100) begin errors++; $display("FAIL rst_restart_pulses got %h required 010100", pl); end
    endtask

    initial begin
        sel = 0; en = 1'b0; valid = 1'b0; l_in = '0; r_in = '0; reset_n = 1'b0;
        test_reset();
        test_lj_basic();
        test_underrun_repeat();
        test_i2s_delay();
        test_underrun_zero();
        test_idle();
        test_padding();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
